seg7_scan_driver: RTL and testbench



---
 rtl/seg7_scan_driver.sv | 118 +++++++++++
 tb/tb_seg7_scan_driver.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with frame-synchronous shadow loading.
// Optional leading-zero suppression is compiled in with `define SEG7_LZ_BLANK_EN.
module seg7_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter bit HEX_EN      = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   num_in,
  input  logic                  load,
  input  logic [DIGITS-1:0]     blank,
  output logic [6:0]            seg_n,
  output logic [DIGITS-1:0]     an_n,
  output logic                  upd_done
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = $clog2(DIGITS);

  logic [DIV_W-1:0]    r_div_cnt;
  logic [IDX_W-1:0]    r_dig_idx;
  logic [4*DIGITS-1:0] r_shadow;
  logic [4*DIGITS-1:0] r_active;
  logic                r_pending;

  logic                w_tick;
  logic                w_frame_end;
  logic [3:0]          w_nibble;
  logic                w_lz_blank;
  logic                w_dark;

  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = HEX_EN ? 7'b0001000 : 7'b0111111;
      4'hB:    seg = HEX_EN ? 7'b0000011 : 7'b0111111;
      4'hC:    seg = HEX_EN ? 7'b1000110 : 7'b0111111;
      4'hD:    seg = HEX_EN ? 7'b0100001 : 7'b0111111;
      4'hE:    seg = HEX_EN ? 7'b0000110 : 7'b0111111;
      default: seg = HEX_EN ? 7'b0001110 : 7'b0111111;
    endcase
    return seg;
  endfunction

  assign w_tick      = (r_div_cnt == DIV_W'(REFRESH_DIV - 1));
  assign w_frame_end = w_tick && (r_dig_idx == IDX_W'(DIGITS - 1));
  assign w_nibble    = r_active[{r_dig_idx, 2'b00} +: 4];

`ifdef SEG7_LZ_BLANK_EN
  logic [DIGITS-1:0] w_lz_mask;

  // A digit is suppressed when it and every more-significant nibble are zero; digit 0 always shows.
  always_comb begin
    logic seen_nz;
    seen_nz   = 1'b0;
    w_lz_mask = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      seen_nz      = seen_nz | (r_active[4*i +: 4] != 4'h0);
      w_lz_mask[i] = ~seen_nz;
    end
  end

  assign w_lz_blank = w_lz_mask[r_dig_idx];
`else
  assign w_lz_blank = 1'b0;
`endif

  assign w_dark = blank[r_dig_idx] | w_lz_blank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_dig_idx <= '0;
      r_shadow  <= '0;
      r_active  <= '0;
      r_pending <= 1'b0;
      upd_done  <= 1'b0;
      an_n      <= '1;
      seg_n     <= 7'b1111111;
    end else begin
      r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
      if (w_tick)
        r_dig_idx <= (r_dig_idx == IDX_W'(DIGITS - 1)) ? '0 : r_dig_idx + IDX_W'(1);

      if (load)
        r_shadow <= num_in;

      // A load landing on the frame boundary bypasses the shadow so it is not delayed a whole frame.
      upd_done <= 1'b0;
      if (w_frame_end && load) begin
        r_active  <= num_in;
        r_pending <= 1'b0;
        upd_done  <= 1'b1;
      end else if (w_frame_end && r_pending) begin
        r_active  <= r_shadow;
        r_pending <= 1'b0;
        upd_done  <= 1'b1;
      end else if (load) begin
        r_pending <= 1'b1;
      end

      an_n  <= ~(DIGITS'(1) << r_dig_idx);
      seg_n <= w_dark ? 7'b1111111 : decode(w_nibble);
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a cycle-level reference model pushes expected pins,
// a negedge monitor pops and compares. Runs two instances (HEX_EN=0 and HEX_EN=1) side by side.
module tb_seg7_scan_driver;

  localparam int D = 4;
  localparam int R = 4;

  logic          clk;
  logic          rst_n;
  logic [4*D-1:0] num_in;
  logic          load;
  logic [D-1:0]  blank;
  logic [6:0]    segN;
  logic [D-1:0]  anN;
  logic          updDone;
  logic [6:0]    segNHex;
  logic [D-1:0]  anNHex;
  logic          updDoneHex;

  int nChecks = 0;
  int nFails  = 0;
  int sk      = 0;

  typedef struct {
    logic [6:0] seg;
    logic [6:0] segHex;
    logic [3:0] an;
    logic       upd;
  } exp_t;

  exp_t expQ[$];

  logic [6:0] decTab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  seg7_scan_driver #(.DIGITS(D), .REFRESH_DIV(R), .HEX_EN(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .num_in(num_in), .load(load), .blank(blank),
    .seg_n(segN), .an_n(anN), .upd_done(updDone)
  );

  seg7_scan_driver #(.DIGITS(D), .REFRESH_DIV(R), .HEX_EN(1'b1)) u_dut_hex (
    .clk(clk), .rst_n(rst_n), .num_in(num_in), .load(load), .blank(blank),
    .seg_n(segNHex), .an_n(anNHex), .upd_done(updDoneHex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] refSeg(input logic [3:0] code, input bit hex);
    if (code > 4'd9 && !hex)
      return 7'b0111111;
    return decTab[code];
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: scan position and frame boundaries follow from the edge count since release.
  int          k = 0;
  logic [15:0] mActive = '0;
  logic [15:0] mShadow = '0;
  bit          mPending = 1'b0;

  always @(posedge clk) begin
    exp_t e;
    int   dig;
    bit   off;
    bit   bnd;
    logic [3:0] nib;
    if (!rst_n) begin
      k = 0;
      mActive = '0;
      mShadow = '0;
      mPending = 1'b0;
      e.seg = 7'b1111111;
      e.segHex = 7'b1111111;
      e.an = 4'hF;
      e.upd = 1'b0;
    end else begin
      dig = (k / R) % D;
      e.an = ~(4'b0001 << dig);
      nib = 4'((mActive >> (4 * dig)) & 16'hF);
      off = blank[dig];
`ifdef SEG7_LZ_BLANK_EN
      if (dig != 0 && (mActive >> (4 * dig)) == 16'h0)
        off = 1'b1;
`endif
      e.seg = off ? 7'b1111111 : refSeg(nib, 1'b0);
      e.segHex = off ? 7'b1111111 : refSeg(nib, 1'b1);
      bnd = (k % (R * D)) == (R * D - 1);
      e.upd = bnd && (load || mPending);
      if (bnd && load) begin
        mActive = num_in;
        mShadow = num_in;
        mPending = 1'b0;
      end else if (bnd && mPending) begin
        mActive = mShadow;
        mPending = 1'b0;
      end else if (load) begin
        mShadow = num_in;
        mPending = 1'b1;
      end
      k++;
    end
    expQ.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("an_n", {4'h0, anN}, {4'h0, e.an});
      checkOutput("seg_n", {1'b0, segN}, {1'b0, e.seg});
      checkOutput("upd_done", {7'h0, updDone}, {7'h0, e.upd});
      checkOutput("an_n_hex", {4'h0, anNHex}, {4'h0, e.an});
      checkOutput("seg_n_hex", {1'b0, segNHex}, {1'b0, e.segHex});
      checkOutput("upd_done_hex", {7'h0, updDoneHex}, {7'h0, e.upd});
    end
  end

  // Inputs set here are sampled at edge sk (edges counted from reset release).
  task automatic applyStimulus(input logic ld, input logic [15:0] val, input logic [3:0] bl);
    load = ld;
    num_in = val;
    blank = bl;
    @(negedge clk);
    #1;
    sk++;
  endtask

  task automatic idleTo(input int target);
    while (sk < target)
      applyStimulus(1'b0, num_in, blank);
  endtask

  task automatic resetPulse(input int cycles);
    rst_n = 1'b0;
    load = 1'b0;
    #1;
    checkOutput("async_reset_an", {4'h0, anN}, 8'h0F);
    checkOutput("async_reset_seg", {1'b0, segN}, 8'h7F);
    repeat (cycles) @(negedge clk);
    #1;
    rst_n = 1'b1;
    sk = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    load = 1'b0;
    num_in = '0;
    blank = '0;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    sk = 0;

    idleTo(21);
    applyStimulus(1'b1, 16'h1928, 4'h0);
    idleTo(47);
    applyStimulus(1'b1, 16'h0007, 4'h0);
    idleTo(64);
    applyStimulus(1'b1, 16'hABCF, 4'h0);
    idleTo(96);
    applyStimulus(1'b1, 16'h1234, 4'h0);
    idleTo(113);
    applyStimulus(1'b0, 16'h0, 4'b0101);
    idleTo(141);
    applyStimulus(1'b0, 16'h0, 4'b0000);
    idleTo(150);
    applyStimulus(1'b1, 16'h1111, 4'h0);
    applyStimulus(1'b1, 16'h2222, 4'h0);
    applyStimulus(1'b1, 16'h0040, 4'h0);
    idleTo(180);
    applyStimulus(1'b1, 16'h0000, 4'h0);
    idleTo(201);
    applyStimulus(1'b1, 16'h5555, 4'h0);
    idleTo(205);
    resetPulse(3);

    for (int i = 0; i < 1500; i++) begin
      logic [3:0] bl;
      bl = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
      applyStimulus($urandom_range(0, 7) == 0, 16'($urandom), bl);
      if (i == 900) begin
        applyStimulus(1'b1, 16'h0300, 4'h0);
        resetPulse(2);
      end
    end

    applyStimulus(1'b0, 16'h0, 4'h0);
    @(negedge clk);
    #2;
    checkOutput("queue_drained", 8'(expQ.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
